// File: rtl/spi_slave.sv
// -----------------------------------------------------------------------------
// spi_slave
//
// SPI peripheral endpoint running in the master's clk domain. sclk is treated
// as an ordinary data input sampled every clk, and its edges are found by
// comparing it with last cycle's value. Each frame receives a DATA_W-bit
// command MSB-first on MOSI, then returns an RSP_W-bit response MSB-first on
// MISO.
//
// Handshake semantics: there is no back-pressure. o_rx_valid is a one-cycle
// pulse qualifying o_rx_data, and o_frame_err is a one-cycle pulse flagging an
// aborted frame. i_tx_load is a one-cycle strobe that the block always accepts.
//
// Ports
//   i_clk        system clock, rising edge
//   i_reset      asynchronous, active-low reset
//   i_cs_n       chip select from master, active low
//   i_sclk       serial clock from master, synchronous to i_clk
//   i_mosi       serial data from master
//   o_miso       serial data to master
//   i_tx_data    response word to send
//   i_tx_load    strobe: latch i_tx_data into the response hold register
//   o_rx_data    last complete command word
//   o_rx_valid   one-cycle pulse, o_rx_data updated this cycle
//   o_busy       high while the FSM is not idle
//   o_frame_err  one-cycle pulse, frame aborted by i_cs_n rising early
//   o_state      current FSM state (0 idle, 1 rx, 2 tx, 3 done)
// -----------------------------------------------------------------------------
module spi_slave #(
    parameter int DATA_W = 16,
    parameter int RSP_W  = 8
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_cs_n,
    input  logic              i_sclk,
    input  logic              i_mosi,
    output logic              o_miso,
    input  logic [RSP_W-1:0]  i_tx_data,
    input  logic              i_tx_load,
    output logic [DATA_W-1:0] o_rx_data,
    output logic              o_rx_valid,
    output logic              o_busy,
    output logic              o_frame_err,
    output logic [1:0]        o_state
);

    localparam int MAX_W = (DATA_W > RSP_W) ? DATA_W : RSP_W;
    localparam int CNT_W = $clog2(MAX_W + 1);
    localparam logic [CNT_W-1:0] RX_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] TX_LAST = CNT_W'(RSP_W - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RX   = 2'd1,
        S_TX   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic              r_sclk_q;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_rx_sh;
    logic [RSP_W-1:0]  r_tx_sh;
    logic [RSP_W-1:0]  r_tx_hold;

    logic w_rise;
    logic w_fall;
    logic w_start;
    logic w_rx_shift;
    logic w_rx_done;
    logic w_tx_rise;
    logic w_tx_shift;
    logic w_abort;

    assign w_rise = i_sclk & ~r_sclk_q;
    assign w_fall = ~i_sclk & r_sclk_q;

    // State register
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state and datapath strobes. cs_n high is checked before any sclk
    // edge so an abort beats a completing rise in the same cycle.
    always_comb begin
        w_next_state = r_state;
        w_start      = 1'b0;
        w_rx_shift   = 1'b0;
        w_rx_done    = 1'b0;
        w_tx_rise    = 1'b0;
        w_tx_shift   = 1'b0;
        w_abort      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!i_cs_n) begin
                    w_next_state = S_RX;
                    w_start      = 1'b1;
                end
            end
            S_RX: begin
                if (i_cs_n) begin
                    w_next_state = S_IDLE;
                    w_abort      = 1'b1;
                end else if (w_rise) begin
                    w_rx_shift = 1'b1;
                    if (r_cnt == RX_LAST) begin
                        w_rx_done    = 1'b1;
                        w_next_state = S_TX;
                    end
                end
            end
            S_TX: begin
                if (i_cs_n) begin
                    w_next_state = S_IDLE;
                    w_abort      = 1'b1;
                end else if (w_rise) begin
                    w_tx_rise = 1'b1;
                    if (r_cnt == TX_LAST) begin
                        w_next_state = S_DONE;
                    end
                end else if (w_fall && (r_cnt != '0)) begin
                    // The fall right after the last command rise precedes any
                    // response rise; shifting then would drop the MSB unseen.
                    w_tx_shift = 1'b1;
                end
            end
            S_DONE: begin
                if (i_cs_n) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Datapath
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_sclk_q    <= 1'b0;
            r_cnt       <= '0;
            r_rx_sh     <= '0;
            r_tx_sh     <= '0;
            r_tx_hold   <= '0;
            o_rx_data   <= '0;
            o_rx_valid  <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            r_sclk_q    <= i_sclk;
            o_rx_valid  <= w_rx_done;
            o_frame_err <= w_abort;

            if (i_tx_load) begin
                r_tx_hold <= i_tx_data;
            end

            if (w_start) begin
                r_cnt   <= '0;
                r_rx_sh <= '0;
            end else if (w_rx_shift) begin
                r_rx_sh <= {r_rx_sh[DATA_W-2:0], i_mosi};
                if (w_rx_done) begin
                    r_cnt <= '0;
                end else if (r_cnt != RX_LAST) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end else if (w_tx_rise && (r_cnt != TX_LAST)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end

            if (w_rx_done) begin
                o_rx_data <= {r_rx_sh[DATA_W-2:0], i_mosi};
                // A load in this very cycle bypasses the hold register.
                r_tx_sh   <= i_tx_load ? i_tx_data : r_tx_hold;
            end else if (w_tx_shift) begin
                r_tx_sh <= {r_tx_sh[RSP_W-2:0], 1'b0};
            end
        end
    end

    assign o_miso  = (r_state == S_TX) ? r_tx_sh[RSP_W-1] : 1'b0;
    assign o_busy  = (r_state != S_IDLE);
    assign o_state = r_state;

endmodule

// File: tb/tb_spi_slave.sv
module tb_spi_slave;

    logic        clk;
    logic        reset;
    logic        cs_n;
    logic        sclk;
    logic        mosi;
    logic        miso;
    logic [7:0]  tx_data;
    logic        tx_load;
    logic [15:0] rx_data;
    logic        rx_valid;
    logic        busy;
    logic        frame_err;
    logic [1:0]  state;

    int n_tests;
    int n_fail;

    // Pulse monitors: number of cycles each pulse was seen high.
    int          rv_cnt;
    int          fe_cnt;
    logic [15:0] rv_word;

    // Reference model: the word the slave should return next frame.
    logic [7:0]  model_hold;
    logic [15:0] model_rx;

    spi_slave #(.DATA_W(16), .RSP_W(8)) dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_cs_n      (cs_n),
        .i_sclk      (sclk),
        .i_mosi      (mosi),
        .o_miso      (miso),
        .i_tx_data   (tx_data),
        .i_tx_load   (tx_load),
        .o_rx_data   (rx_data),
        .o_rx_valid  (rx_valid),
        .o_busy      (busy),
        .o_frame_err (frame_err),
        .o_state     (state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_valid) begin
            rv_cnt  = rv_cnt + 1;
            rv_word = rx_data;
        end
        if (frame_err) fe_cnt = fe_cnt + 1;
    end

    task automatic wait_clk(input int n);
        for (int k = 0; k < n; k++) @(negedge clk);
    endtask

    task automatic clear_mon();
        rv_cnt = 0;
        fe_cnt = 0;
    endtask

    task automatic do_load(input logic [7:0] v);
        tx_data = v;
        tx_load = 1'b1;
        @(negedge clk);
        tx_load = 1'b0;
        model_hold = v;
    endtask

    // Send n_bits command bits MSB-first. On the last rise optionally raise
    // cs_n (abort) or pulse tx_load together with the rise.
    task automatic send_cmd(input logic [15:0] cmd, input int n_bits,
                            input bit abort_last, input bit load_last,
                            input logic [7:0] load_val);
        for (int i = 15; i > 15 - n_bits; i--) begin
            mosi = cmd[i];
            wait_clk(2);
            sclk = 1'b1;
            if (i == 16 - n_bits) begin
                if (abort_last) cs_n = 1'b1;
                if (load_last) begin
                    tx_data = load_val;
                    tx_load = 1'b1;
                    model_hold = load_val;
                end
            end
            @(negedge clk);
            tx_load = 1'b0;
            @(negedge clk);
            sclk = 1'b0;
        end
    endtask

    // Clock out n response bits, sampling miso just before each rise.
    task automatic recv_rsp(input int n, output logic [7:0] got);
        got = '0;
        for (int i = 7; i > 7 - n; i--) begin
            wait_clk(2);
            got[i] = miso;
            sclk = 1'b1;
            wait_clk(2);
            sclk = 1'b0;
        end
    endtask

    task automatic full_frame(input logic [15:0] cmd, input bit load_last,
                              input logic [7:0] load_val, output logic [7:0] got);
        clear_mon();
        cs_n = 1'b0;
        wait_clk(2);
        send_cmd(cmd, 16, 1'b0, load_last, load_val);
        recv_rsp(8, got);
        wait_clk(2);
        cs_n = 1'b1;
        wait_clk(3);
    endtask

    task automatic check_frame(input string name, input logic [15:0] cmd,
                               input logic [7:0] exp_rsp, input logic [7:0] got);
        n_tests++;
        if (rv_cnt !== 1) begin
            n_fail++;
            $display("FAIL %s rx_valid_cycles got=%0d exp=1", name, rv_cnt);
        end
        n_tests++;
        if (rv_word !== cmd || rx_data !== cmd) begin
            n_fail++;
            $display("FAIL %s rx_data got=%h/%h exp=%h", name, rv_word, rx_data, cmd);
        end
        n_tests++;
        if (got !== exp_rsp) begin
            n_fail++;
            $display("FAIL %s miso got=%h exp=%h", name, got, exp_rsp);
        end
        n_tests++;
        if (fe_cnt !== 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s idle_after fe=%0d busy=%b exp fe=0 busy=0", name, fe_cnt, busy);
        end
        model_rx = cmd;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        wait_clk(3);
        reset = 1'b1;
        wait_clk(2);
        n_tests++;
        if (miso !== 1'b0 || busy !== 1'b0 || rx_data !== 16'h0 ||
            rx_valid !== 1'b0 || frame_err !== 1'b0 || state !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_state miso=%b busy=%b rx=%h rv=%b fe=%b st=%0d exp all 0",
                     miso, busy, rx_data, rx_valid, frame_err, state);
        end
    endtask

    task automatic test_basic();
        logic [7:0] got;
        do_load(8'hA5);
        full_frame(16'hC3E1, 1'b0, 8'h00, got);
        check_frame("basic", 16'hC3E1, 8'hA5, got);
    endtask

    task automatic test_abort(input string name, input int n_bits, input bit at_last);
        clear_mon();
        cs_n = 1'b0;
        wait_clk(2);
        send_cmd($urandom_range(0, 16'hFFFF), n_bits, at_last, 1'b0, 8'h00);
        if (!at_last) cs_n = 1'b1;
        wait_clk(3);
        n_tests++;
        if (fe_cnt !== 1 || rv_cnt !== 0) begin
            n_fail++;
            $display("FAIL %s pulses fe=%0d rv=%0d exp fe=1 rv=0", name, fe_cnt, rv_cnt);
        end
        n_tests++;
        if (rx_data !== model_rx || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s hold rx=%h busy=%b exp rx=%h busy=0", name, rx_data, busy, model_rx);
        end
    endtask

    task automatic test_bypass();
        logic [7:0] got;
        do_load(8'h5A);
        full_frame(16'h1234, 1'b1, 8'h81, got);
        check_frame("bypass", 16'h1234, 8'h81, got);
    endtask

    task automatic test_back_to_back();
        logic [7:0] got;
        logic [7:0] old_hold;
        old_hold = model_hold;
        full_frame(16'h0001, 1'b0, 8'h00, got);
        check_frame("b2b_first", 16'h0001, old_hold, got);
        do_load(8'h3C);
        full_frame(16'hFFFF, 1'b0, 8'h00, got);
        check_frame("b2b_second", 16'hFFFF, 8'h3C, got);
    endtask

    task automatic test_random();
        logic [7:0]  got;
        logic [15:0] cmd;
        logic [7:0]  exp;
        for (int r = 0; r < 6; r++) begin
            cmd = 16'($urandom_range(0, 16'hFFFF));
            if ($urandom_range(0, 1) == 1) do_load(8'($urandom_range(0, 255)));
            if ($urandom_range(0, 2) == 0) begin
                full_frame(cmd, 1'b1, 8'($urandom_range(0, 255)), got);
            end else begin
                exp = model_hold;
                full_frame(cmd, 1'b0, 8'h00, got);
                model_hold = exp;
            end
            check_frame("random", cmd, model_hold, got);
        end
    endtask

    task automatic test_idle_edges();
        int bad;
        bad = 0;
        clear_mon();
        cs_n = 1'b1;
        for (int c = 0; c < 40; c++) begin
            sclk = ~sclk;
            mosi = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (busy !== 1'b0 || miso !== 1'b0 || state !== 2'd0) bad++;
        end
        sclk = 1'b0;
        wait_clk(2);
        n_tests++;
        if (bad != 0 || rv_cnt != 0 || fe_cnt != 0) begin
            n_fail++;
            $display("FAIL idle_edges bad_cycles=%0d rv=%0d fe=%0d exp 0/0/0", bad, rv_cnt, fe_cnt);
        end
    endtask

    task automatic test_reset_mid_tx();
        logic [7:0] got;
        do_load(8'hFF);
        cs_n = 1'b0;
        wait_clk(2);
        send_cmd(16'hBEEF, 16, 1'b0, 1'b0, 8'h00);
        recv_rsp(3, got);
        wait_clk(1);
        n_tests++;
        if (busy !== 1'b1 || miso !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_tx_pre busy=%b miso=%b exp 1/1", busy, miso);
        end
        #2 reset = 1'b0;
        #1;
        n_tests++;
        if (miso !== 1'b0 || busy !== 1'b0 || rx_data !== 16'h0) begin
            n_fail++;
            $display("FAIL async_reset miso=%b busy=%b rx=%h exp 0/0/0000", miso, busy, rx_data);
        end
        model_hold = 8'h00;
        model_rx   = 16'h0;
        @(negedge clk);
        cs_n = 1'b1;
        sclk = 1'b0;
        mosi = 1'b0;
        wait_clk(2);
        reset = 1'b1;
        wait_clk(2);
        full_frame(16'h6A6A, 1'b0, 8'h00, got);
        check_frame("post_reset", 16'h6A6A, 8'h00, got);
    endtask

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        rv_cnt     = 0;
        fe_cnt     = 0;
        rv_word    = '0;
        model_hold = 8'h00;
        model_rx   = 16'h0;
        reset      = 1'b1;
        cs_n       = 1'b1;
        sclk       = 1'b0;
        mosi       = 1'b0;
        tx_data    = 8'h00;
        tx_load    = 1'b0;
        #2;

        test_reset();
        test_basic();
        test_abort("abort_9", 9, 1'b0);
        test_abort("abort_at_16", 16, 1'b1);
        test_bypass();
        test_back_to_back();
        test_random();
        test_idle_edges();
        test_reset_mid_tx();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
